mmio_tx_port: RTL

Memory-mapped transmit port on the 32-bit CPU's data-memory bus, beside data memory inside `top`. Consumes the CPU store interface (`MemWrite`, `DataAdr`, `WriteData`), queues stored words in a small FIFO and serializes them as a byte stream with valid/ready handshake. Benches and boards observe program output through this stream instead of probing register-file internals. Exposes a status word for software polling.

---
 rtl/mmio_pkg.sv | 35 +++
 rtl/sync_fifo.sv | 70 +++++++
 rtl/mmio_tx_port.sv | 138 +++++++++++++
 3 files changed

// File: rtl/mmio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mmio_pkg
// Description : Shared constants and types for the MMIO transmit port:
//               store addresses, status bit positions, FIFO entry layout
//               and serializer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package mmio_pkg;

    // Store / read addresses on the CPU data-memory bus
    localparam logic [31:0] ADDR_WORD      = 32'h0000_0100;
    localparam logic [31:0] ADDR_BYTE      = 32'h0000_0104;
    localparam logic [31:0] ADDR_STATUS    = 32'h0000_0108;

    // Status word layout
    localparam int          STAT_FULL_BIT  = 0;
    localparam int          STAT_IDLE_BIT  = 1;
    localparam int          STAT_OVF_BIT   = 2;
    localparam int          STAT_COUNT_LSB = 8;

    // FIFO entry: {len, data[31:0]}; len selects how many bytes are sent
    localparam int          ENTRY_W        = 33;
    localparam int          ENTRY_LEN_BIT  = 32;
    localparam logic        LEN_WORD       = 1'b1;
    localparam logic        LEN_BYTE       = 1'b0;

    // Serializer states
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with occupancy count. Pointers wrap
//               naturally; the count separates full from empty. Push while
//               full and pop while empty are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [WIDTH-1:0]           i_wdata,
    output logic [WIDTH-1:0]           o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage array: data only, no reset needed since count gates reads
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/mmio_tx_port.sv
`default_nettype none
// ============================================================================
// Module      : mmio_tx_port
// Description : Memory-mapped transmit port. Decodes CPU stores, queues
//               word/byte entries in a FIFO and serializes them
//               little-endian onto a valid/ready byte stream. Provides a
//               pollable status word with a sticky overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_tx_port
    import mmio_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] status_rdata,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready
);

    localparam int CW = $clog2(DEPTH+1);

    logic               w_word_st;
    logic               w_byte_st;
    logic               w_stat_st;
    logic               w_push_req;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic               w_last;
    logic [CW-1:0]      w_count;
    logic [ENTRY_W-1:0] w_wentry;
    logic [ENTRY_W-1:0] w_head;

    tx_state_t          r_state;
    logic [1:0]         r_idx;
    logic [ENTRY_W-1:0] r_hold;
    logic               r_overflow;

    // Store decode
    assign w_word_st  = MemWrite && (DataAdr == ADDR_WORD);
    assign w_byte_st  = MemWrite && (DataAdr == ADDR_BYTE);
    assign w_stat_st  = MemWrite && (DataAdr == ADDR_STATUS);
    assign w_push_req = w_word_st || w_byte_st;
    // Full is the registered value, so a same-cycle pop never makes room
    assign w_push     = w_push_req && !w_full;
    assign w_wentry   = {(w_word_st ? LEN_WORD : LEN_BYTE), WriteData};

    // Last byte of the held entry: byte 3 for words, byte 0 for bytes
    assign w_last = (r_hold[ENTRY_LEN_BIT] == LEN_WORD) ? (r_idx == 2'd3)
                                                        : (r_idx == 2'd0);

    // Fetch from the FIFO when idle, or right after the last byte handshakes
    assign w_pop = !w_empty &&
                   ((r_state == IDLE) || ((r_state == SEND) && tx_ready && w_last));

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_wentry),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Sticky overflow: a dropped push takes priority over a status-store clear
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_overflow <= 1'b0;
        end else if (w_push_req && w_full) begin
            r_overflow <= 1'b1;
        end else if (w_stat_st) begin
            r_overflow <= 1'b0;
        end
    end

    // Serializer: holds one entry and walks its bytes LSB first
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_idx   <= 2'd0;
            r_hold  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        r_hold  <= w_head;
                        r_idx   <= 2'd0;
                        r_state <= SEND;
                    end
                end
                SEND: begin
                    if (tx_ready) begin
                        if (w_last) begin
                            r_idx <= 2'd0;
                            if (!w_empty) begin
                                r_hold <= w_head;
                            end else begin
                                r_state <= IDLE;
                            end
                        end else begin
                            r_idx <= r_idx + 2'd1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign tx_valid = (r_state == SEND);
    assign tx_data  = r_hold[{r_idx, 3'b000} +: 8];

    // Status word built from registered state only
    always_comb begin
        status_rdata                          = '0;
        status_rdata[STAT_FULL_BIT]           = w_full;
        status_rdata[STAT_IDLE_BIT]           = w_empty && (r_state == IDLE);
        status_rdata[STAT_OVF_BIT]            = r_overflow;
        status_rdata[STAT_COUNT_LSB +: CW]    = w_count;
    end

endmodule
`default_nettype wire
